// File: rtl/mmul_host_pkg.sv
// Shared definitions for the modular-multiplier host controller.
// Holds the sequencer state encoding and the operand/word geometry.
package mmul_host_pkg;

   localparam int WORD_W  = 16;
   localparam int N_WORDS = 16;
   localparam int OP_W    = 256;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      LOAD_P,
      KICK,
      WAIT_RDY,
      UNLOAD,
      DONE
   } state_t;

endpackage

// File: rtl/mmul_word_ser.sv
// Operand/result word serialiser: parallel load, LSW shift-out, MSW shift-in.
// Ports: clk, rst (async active-low), load/load_val, shift/din, data (full reg).
module mmul_word_ser
   import mmul_host_pkg::*;
#(
   parameter int OW = OP_W,
   parameter int WW = WORD_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [OW-1:0] load_val,
   input  logic          shift,
   input  logic [WW-1:0] din,
   output logic [OW-1:0] data
);

   // Shifting right presents the next word at data[WW-1:0] while a new
   // word enters at the top, so 16 shifts reassemble an LSW-first stream.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data <= '0;
      end else if (load) begin
         data <= load_val;
      end else if (shift) begin
         data <= {din, data[OW-1:WW]};
      end
   end

endmodule

// File: rtl/mmul_host.sv
// Host sequencer for a 256-bit modular multiplier: loads A/B/P word-serially,
// kicks the core, waits for ready (with timeout) and unloads C/D/B.
// Ports: clk, rst (async active-low), start, op_a/op_b/op_p, busy, done,
// timeout, res_c/res_d/res_b, flag, datain, load/out strobes, mmul_en,
// mmul_rdy, c_flag, regcout/regdout/regbout.
module mmul_host #(
   parameter int WORD_W  = mmul_host_pkg::WORD_W,
   parameter int N_WORDS = mmul_host_pkg::N_WORDS,
   parameter int TO_W    = 24
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [mmul_host_pkg::OP_W-1:0]  op_a,
   input  logic [mmul_host_pkg::OP_W-1:0]  op_b,
   input  logic [mmul_host_pkg::OP_W-1:0]  op_p,
   output logic                            busy,
   output logic                            done,
   output logic                            timeout,
   output logic [mmul_host_pkg::OP_W-1:0]  res_c,
   output logic [mmul_host_pkg::OP_W-1:0]  res_d,
   output logic [mmul_host_pkg::OP_W-1:0]  res_b,
   output logic [1:0]                      flag,
   output logic [WORD_W-1:0]               datain,
   output logic                            loada,
   output logic                            loadb,
   output logic                            loadp,
   output logic                            mmul_en,
   output logic                            outc,
   output logic                            outd,
   output logic                            outb,
   input  logic                            mmul_rdy,
   input  logic [1:0]                      c_flag,
   input  logic [WORD_W-1:0]               regcout,
   input  logic [WORD_W-1:0]               regdout,
   input  logic [WORD_W-1:0]               regbout
);

   import mmul_host_pkg::*;

   localparam logic [4:0] LAST  = 5'(N_WORDS - 1);
   localparam logic [4:0] FLUSH = 5'(N_WORDS);

   state_t          state;
   logic [4:0]      cnt;
   logic [TO_W-1:0] to_cnt;
   logic [TO_W-1:0] to_nxt;
   logic            ld_ops;
   logic            cap;
   logic [OP_W-1:0] a_q;
   logic [OP_W-1:0] b_q;
   logic [OP_W-1:0] p_q;

   assign ld_ops = (state == IDLE) && start;
   // Word k arrives one cycle after strobe k, so capture skips cnt 0
   // and runs one cycle past the last strobe.
   assign cap    = (state == UNLOAD) && (cnt != '0);
   assign to_nxt = to_cnt + 1'b1;

   mmul_word_ser #(.OW(OP_W), .WW(WORD_W)) u_ser_a (
      .clk(clk), .rst(rst), .load(ld_ops), .load_val(op_a),
      .shift(state == LOAD_A), .din('0), .data(a_q)
   );

   mmul_word_ser #(.OW(OP_W), .WW(WORD_W)) u_ser_b (
      .clk(clk), .rst(rst), .load(ld_ops), .load_val(op_b),
      .shift(state == LOAD_B), .din('0), .data(b_q)
   );

   mmul_word_ser #(.OW(OP_W), .WW(WORD_W)) u_ser_p (
      .clk(clk), .rst(rst), .load(ld_ops), .load_val(op_p),
      .shift(state == LOAD_P), .din('0), .data(p_q)
   );

   mmul_word_ser #(.OW(OP_W), .WW(WORD_W)) u_res_c (
      .clk(clk), .rst(rst), .load(1'b0), .load_val('0),
      .shift(cap), .din(regcout), .data(res_c)
   );

   mmul_word_ser #(.OW(OP_W), .WW(WORD_W)) u_res_d (
      .clk(clk), .rst(rst), .load(1'b0), .load_val('0),
      .shift(cap), .din(regdout), .data(res_d)
   );

   mmul_word_ser #(.OW(OP_W), .WW(WORD_W)) u_res_b (
      .clk(clk), .rst(rst), .load(1'b0), .load_val('0),
      .shift(cap), .din(regbout), .data(res_b)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         to_cnt  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         timeout <= 1'b0;
         flag    <= '0;
         datain  <= '0;
         loada   <= 1'b0;
         loadb   <= 1'b0;
         loadp   <= 1'b0;
         mmul_en <= 1'b0;
         outc    <= 1'b0;
         outd    <= 1'b0;
         outb    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  // Shadow regs load on this edge, so word 0 comes
                  // straight from the port.
                  state   <= LOAD_A;
                  busy    <= 1'b1;
                  timeout <= 1'b0;
                  loada   <= 1'b1;
                  datain  <= op_a[WORD_W-1:0];
                  cnt     <= '0;
               end
            end
            LOAD_A: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state  <= LOAD_B;
                  cnt    <= '0;
                  loada  <= 1'b0;
                  loadb  <= 1'b1;
                  datain <= b_q[WORD_W-1:0];
               end else begin
                  datain <= a_q[2*WORD_W-1:WORD_W];
               end
            end
            LOAD_B: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state  <= LOAD_P;
                  cnt    <= '0;
                  loadb  <= 1'b0;
                  loadp  <= 1'b1;
                  datain <= p_q[WORD_W-1:0];
               end else begin
                  datain <= b_q[2*WORD_W-1:WORD_W];
               end
            end
            LOAD_P: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state   <= KICK;
                  loadp   <= 1'b0;
                  datain  <= '0;
                  mmul_en <= 1'b1;
               end else begin
                  datain <= p_q[2*WORD_W-1:WORD_W];
               end
            end
            KICK: begin
               // Ready seen here belongs to a previous job; not sampled.
               state   <= WAIT_RDY;
               mmul_en <= 1'b0;
               to_cnt  <= '0;
            end
            WAIT_RDY: begin
               if (mmul_rdy) begin
                  state <= UNLOAD;
                  flag  <= c_flag;
                  cnt   <= '0;
                  outc  <= 1'b1;
                  outd  <= 1'b1;
                  outb  <= 1'b1;
               end else begin
                  to_cnt <= to_nxt;
                  if (&to_nxt) begin
                     state   <= DONE;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     timeout <= 1'b1;
                  end
               end
            end
            UNLOAD: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  outc <= 1'b0;
                  outd <= 1'b0;
                  outb <= 1'b0;
               end
               if (cnt == FLUSH) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mmul_host.md
MMUL_HOST -- requirements
Module: mmul_host

Interface
REQ-001 Parameters: WORD_W, 16, bus word width; N_WORDS, 16, words per 256-bit operand; TO_W, 24, timeout counter width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; one-cycle pulse, accepted only when busy=0.
REQ-005 op_a, op_b, op_p  input  256 each  multiplicand, multiplier, modulus; sampled on the accepted start.
REQ-006 busy  output  1  high from the accepted start until done.
REQ-007 done  output  1  one-cycle pulse when results are valid.
REQ-008 timeout  output  1  set with done when mmul_rdy never arrived; cleared by the next accepted start.
REQ-009 res_c, res_d, res_b  output  256 each  collected unload words; held until the next accepted start.
REQ-010 flag  output  2  c_flag sampled in the cycle mmul_rdy is seen.
REQ-011 datain  output  16  word to multiplier; LSW first.
REQ-012 loada, loadb, loadp, mmul_en, outc, outd, outb  output  1 each  multiplier strobes.
REQ-013 mmul_rdy  input  1; c_flag  input  2; regcout, regdout, regbout  input  16 each.

Function
REQ-014 FSM states: IDLE, LOAD_A, LOAD_B, LOAD_P, KICK, WAIT_RDY, UNLOAD, DONE.
REQ-015 IDLE with start=1: latch op_a/op_b/op_p into shadow registers, clear timeout, go to LOAD_A; start=1 in any other state is ignored.
REQ-016 LOAD_A/LOAD_B/LOAD_P: 16 cycles each; in cycle k (0..15) the matching strobe =1 and datain = operand[16k+15:16k]; exactly one load strobe high at a time.
REQ-017 Timing from start cycle T: loada T+1..T+16, loadb T+17..T+32, loadp T+33..T+48, mmul_en =1 only at T+49.
REQ-018 WAIT_RDY from T+50; mmul_rdy sampled in the KICK cycle is ignored (stale ready).
REQ-019 WAIT_RDY: first cycle with mmul_rdy=1 captures c_flag into flag and enters UNLOAD next cycle.
REQ-020 Timeout counter counts WAIT_RDY cycles; at all-ones go to DONE with timeout=1 and results left unchanged from the previous run.
REQ-021 UNLOAD: outc=outd=outb=1 for exactly 16 cycles; word k of regcout/regdout/regbout is captured in the cycle after strobe cycle k into res_*[16k+15:16k].
REQ-022 DONE: reached the cycle after the 16th capture; done=1 for one cycle, busy=0 from the same cycle, then return to IDLE.
REQ-023 start asserted in the DONE cycle is ignored.
REQ-024 datain = 0 whenever no load strobe is high.
REQ-025 All strobes, datain and done are registered outputs (no combinational path from inputs).

Reset
REQ-026 rst=0 asynchronously forces IDLE, counters 0, all strobes 0, datain 0, busy 0, done 0, timeout 0, flag 0, res_* 0.
REQ-027 Reset mid-operation abandons the transfer; after release the block stays in IDLE until a new start.

Structure
REQ-028 Shared package holds: state encoding, WORD_W, N_WORDS, operand width 256.
REQ-029 One sub-module, mmul_word_ser, is natural: 256-bit shift register with load, 16-bit shift-out and shift-in, instanced for operand serialisation and for each result.

Verification
REQ-030 Reset: rst=0 mid-LOAD_B -> all strobes 0 immediately, busy 0, no mmul_en afterwards.
REQ-031 Load order: op_a = 256'h32C4AE2C_..._334C74C7 -> datain 16'h74C7 at T+1, 16'h32C4 at T+16; loadb rises at T+17; mmul_en high only at T+49.
REQ-032 Full run against behavioural MMUL model with op_p = 256'hFFFFFFFE_FFFFFFFF_..._FFFFFFFF -> res_c == (op_a*op_b) mod op_p; done is a single pulse.
REQ-033 Stale ready: mmul_rdy held high through KICK, dropped at T+50, raised at T+60 -> UNLOAD starts at T+61.
REQ-034 Timeout: mmul_rdy tied 0, TO_W=4 -> done with timeout=1 after 15 WAIT_RDY cycles; res_* unchanged.
REQ-035 start pulsed while busy and in the DONE cycle -> ignored; a second start after done runs normally.
